latch_d: RTL and testbench
==========================

Name: latch_d

Overview:
- Level-sensitive transparent D latch; the primitive storage element of the emulator library.
- While enable is high, out follows in combinationally; while enable is low, out holds the last value passed.
- A clocked side-channel, on the single clock, provides:
  - a registered copy of the latched value;
  - an update strobe;
  - a saturating hold-duration counter, for pipeline and debug use.

Parameters:
- WIDTH, 1, bit width of in/out/out_q.
- CNT_W, 8, width of hold_cycles counter.

Ports:
- clk  input  1  rising-edge clock for the registered side-channel only; the latch path never depends on it.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  data input.
- enable  input  1  latch enable; 1 = transparent, 0 = hold.
- out  output  WIDTH  latch output.
- out_q  output  WIDTH  out registered on clk.
- updated  output  1  one-cycle pulse: out_q changed on this edge.
- hold_cycles  output  CNT_W  clk edges elapsed since enable last seen high (saturating).

Behaviour:
- Latch path:
  - enable=1: out = in with zero-cycle, purely combinational latency; every change of in propagates.
  - enable=0: out keeps the value present at the instant enable fell; in changes are ignored.
  - enable rising while held: out immediately takes the current in.
  - Simultaneous in change and enable fall: the value of in before the change is held.
- Reset:
  - reset=1 asynchronously forces the stored latch value to 0 and overrides enable.
  - While reset=1: out=0, out_q=0, updated=0, hold_cycles=0.
  - On reset release, the latch resumes normal function immediately; if enable=1, out = in at once.
- Floating control inputs:
  - reset counts as asserted only when it is exactly logic 1; z or x is treated as deasserted.
  - With clk and reset unconnected, the latch path (in/enable/out) must still function fully and deterministically.
  - With clk unconnected, out_q, updated and hold_cycles may stay at their power-up value of 0.
- Initial state: the stored value is 0 before any enable pulse (no X on out at time 0).
- Registered side-channel, at each rising edge of clk with reset=0:
  - out_q <= out (one-cycle latency).
  - updated <= 1 if the new out_q differs from the previous out_q, else 0.
  - hold_cycles <= 0 if enable=1; else hold_cycles+1, saturating at 2^CNT_W-1 with no wrap.
- Width rule: all WIDTH bits latch together under the single enable; there is no per-bit enable.

Test Plan:
- Transparency:
  - reset=0, enable=1, in=0, wait 10 -> out=0.
  - in=1, wait 10 -> out=1.
- Hold:
  - enable=1, in=1, then enable=0 -> out=1.
  - Toggle in 0,1,0 with 10-unit gaps -> out stays 1 throughout.
- Re-open: after the hold above, enable=1 with in=0 -> out=0 within the same timestep.
- Floating clk/reset: instantiate with only in/enable/out connected, then repeat the three scenarios above -> identical results, no X on out.
- Async reset:
  - enable=0 holding 1, pulse reset=1 between clock edges -> out=0 and out_q=0 immediately.
  - Release reset with enable=1, in=1 -> out=1 at once; out_q=1 after the next clk edge, with updated=1 for one cycle.
- Hold counter, CNT_W=2:
  - enable=0 for 5 clk edges -> hold_cycles = 1, 2, 3, 3, 3.
  - enable=1 for 1 edge -> hold_cycles=0.

Source files
------------

// File: rtl/latch_d.sv
// Transparent D latch with a clocked side-channel: a registered copy of the output,
// a change strobe and a saturating count of clock edges spent in hold.
module latch_d #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             updated,
    output logic [CNT_W-1:0] hold_cycles
);

    localparam logic [CNT_W-1:0] HOLD_MAX = '1;

    // Only a solid 1 resets; a floating or unknown reset pin leaves the latch working.
    logic rst_active;
    assign rst_active = (reset === 1'b1);

    logic [WIDTH-1:0] latch_d;
    logic [WIDTH-1:0] latch_q;

    assign latch_d = in;

    always_latch begin
        if (rst_active) begin
            latch_q <= '0;
        end else if (enable) begin
            latch_q <= latch_d;
        end
    end

    // Bypass the storage node while open so in reaches out in the same timestep.
    always_comb begin
        out = latch_q;
        if (rst_active) begin
            out = '0;
        end else if (enable) begin
            out = in;
        end
    end

    logic [WIDTH-1:0] oq_d;
    logic [WIDTH-1:0] oq_q;
    logic             upd_d;
    logic             upd_q;
    logic [CNT_W-1:0] hold_d;
    logic [CNT_W-1:0] hold_q;

    always_comb begin
        oq_d   = out;
        upd_d  = (out != oq_q);
        hold_d = hold_q;
        if (enable) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset === 1'b1) begin
            oq_q   <= '0;
            upd_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            oq_q   <= oq_d;
            upd_q  <= upd_d;
            hold_q <= hold_d;
        end
    end

    assign out_q       = oq_q;
    assign updated     = upd_q;
    assign hold_cycles = hold_q;

endmodule

// File: tb/tb_latch_d.sv
// Bench for latch_d: directed scenarios plus randomized traffic checked against a
// behavioural model, and a second instance with clk/reset left floating.
module tb_latch_d;

    localparam int W  = 4;
    localparam int CW = 2;
    localparam int HMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in;
    logic          enable;
    logic [W-1:0]  out;
    logic [W-1:0]  out_q;
    logic          updated;
    logic [CW-1:0] hold_cycles;

    // Floating-control instance: clk and reset are driven to z.
    logic       f_clk = 1'bz;
    logic       f_reset = 1'bz;
    logic [0:0] f_in;
    logic       f_en;
    logic [0:0] f_out;
    logic [0:0] f_out_q;
    logic       f_updated;
    logic [7:0] f_hold;

    int checks = 0;
    int errors = 0;

    // Model state: value last passed by the latch, and the side-channel registers.
    logic [W-1:0] m_store = '0;
    logic [W-1:0] m_oq    = '0;
    logic         m_upd   = 1'b0;
    int           m_hold  = 0;

    always #5 clk = ~clk;

    latch_d #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in(in), .enable(enable),
        .out(out), .out_q(out_q), .updated(updated), .hold_cycles(hold_cycles)
    );

    latch_d dut_f (
        .clk(f_clk), .reset(f_reset), .in(f_in), .enable(f_en),
        .out(f_out), .out_q(f_out_q), .updated(f_updated), .hold_cycles(f_hold)
    );

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            m_upd  = (m_store != m_oq);
            m_oq   = m_store;
            m_hold = enable ? 0 : ((m_hold + 1 > HMAX) ? HMAX : m_hold + 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Change inputs, update the model, then check the latch output one unit later.
    task automatic drive(input logic r, input logic e, input logic [W-1:0] d, input string tag);
        reset  = r;
        enable = e;
        in     = d;
        if (r) begin
            m_store = '0;
            m_oq    = '0;
            m_upd   = 1'b0;
            m_hold  = 0;
        end else if (e) begin
            m_store = d;
        end
        #1;
        check({tag, ".out"}, 32'(out), 32'(m_store));
        if (r) begin
            check({tag, ".rst_out_q"}, 32'(out_q), 32'd0);
            check({tag, ".rst_upd"}, 32'(updated), 32'd0);
            check({tag, ".rst_hold"}, 32'(hold_cycles), 32'd0);
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        check({tag, ".out_q"}, 32'(out_q), 32'(m_oq));
        check({tag, ".updated"}, 32'(updated), 32'(m_upd));
        check({tag, ".hold"}, 32'(hold_cycles), 32'(m_hold));
    endtask

    initial begin
        f_in = 1'b0;
        f_en = 1'b0;
        drive(1'b1, 1'b0, 4'h0, "reset");
        tick("reset");

        // Transparency
        drive(1'b0, 1'b1, 4'h0, "transp0");
        check("transp0.const", 32'(out), 32'h0);
        tick("transp0");
        drive(1'b0, 1'b1, 4'hF, "transp1");
        check("transp1.const", 32'(out), 32'hF);
        tick("transp1");

        // Hold: in toggles while enable is low
        drive(1'b0, 1'b0, 4'hF, "hold_fall");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, (i % 2 == 0) ? 4'h0 : 4'hF, "hold_toggle");
            check("hold_toggle.const", 32'(out), 32'hF);
            tick("hold_toggle");
        end

        // Re-open
        drive(1'b0, 1'b1, 4'h0, "reopen");
        check("reopen.const", 32'(out), 32'h0);
        tick("reopen");

        // Async reset between edges while holding a nonzero value
        drive(1'b0, 1'b1, 4'hA, "pre_rst");
        drive(1'b0, 1'b0, 4'hA, "pre_rst_hold");
        tick("pre_rst");
        tick("pre_rst2");
        #2;
        drive(1'b1, 1'b0, 4'hA, "async_rst");
        check("async_rst.const", 32'(out), 32'h0);
        drive(1'b0, 1'b1, 4'hA, "rst_release");
        check("rst_release.const", 32'(out), 32'hA);
        tick("rst_release");
        check("rst_release.upd_const", 32'(updated), 32'd1);
        tick("rst_release2");
        check("rst_release2.upd_const", 32'(updated), 32'd0);

        // Hold counter saturation at 3 with CNT_W=2
        drive(1'b0, 1'b0, 4'h5, "cnt");
        for (int i = 1; i <= 5; i++) begin
            tick("cnt");
            check("cnt.const", 32'(hold_cycles), 32'((i > 3) ? 3 : i));
        end
        drive(1'b0, 1'b1, 4'h5, "cnt_clr");
        tick("cnt_clr");
        check("cnt_clr.const", 32'(hold_cycles), 32'd0);

        // Randomized traffic, with mid-cycle input changes and occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), "rand");
            if ($urandom_range(0, 1) == 1)
                drive(1'b0, enable, 4'($urandom), "rand_mid");
            if (reset === 1'b1)
                drive(1'b0, 1'($urandom), 4'($urandom), "rand_rel");
            tick("rand");
        end

        // Floating clk/reset instance: transparency, hold, re-open
        f_en = 1'b1; f_in = 1'b0; #10;
        check("float.transp0", 32'(f_out), 32'd0);
        f_in = 1'b1; #10;
        check("float.transp1", 32'(f_out), 32'd1);
        f_en = 1'b0; #1;
        check("float.hold", 32'(f_out), 32'd1);
        for (int i = 0; i < 3; i++) begin
            f_in = (i % 2 == 0) ? 1'b0 : 1'b1; #10;
            check("float.hold_toggle", 32'(f_out), 32'd1);
        end
        f_in = 1'b0; f_en = 1'b1; #1;
        check("float.reopen", 32'(f_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
